ext_mem_ctrl: RTL and testbench



---
 rtl/ext_mem_pkg.sv | 20 ++
 rtl/ext_mem_cycle_ctr.sv | 27 ++
 rtl/ext_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_ext_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external-memory controller.
package ext_mem_pkg;

   localparam int CTR_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DATA  = 3'd3,
      ST_RESP  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   // Byte offset from the SRAM base is in range when below words*4; widened so large depths do not wrap.
   function automatic logic addr_in_range(input logic [31:0] off, input logic [31:0] words);
      return {2'b00, off} < {words, 2'b00};
   endfunction

endpackage

// File: rtl/ext_mem_cycle_ctr.sv
// Loadable down-counter with a done flag; times both the wait-state and read-latency phases.
module ext_mem_cycle_ctr
   import ext_mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CTR_W-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [CTR_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CTR_W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/ext_mem_ctrl.sv
// Services the core's external memory stream from a synchronous word-wide SRAM,
// inserting wait states and read latency, and flagging out-of-range or illegal accesses.
module ext_mem_ctrl
   import ext_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int          MEM_WORDS    = 16384,
   parameter int          ADDR_W       = $clog2(MEM_WORDS),
   parameter int          WAIT_STATES  = 0,
   parameter int          READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ext_valid,
   input  logic              ext_instruction,
   input  logic [31:0]       ext_address,
   input  logic [31:0]       ext_write_data,
   input  logic [3:0]        ext_write_strobe,
   output logic              ext_ready,
   output logic [31:0]       ext_read_data,
   output logic              bus_err,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   // Handshake: the core raises ext_valid and holds it with its fields until ext_ready;
   // a request is taken only in IDLE, and ext_ready pulses for exactly one cycle per accepted request.

   localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   localparam logic [CTR_W-1:0] DATA_LOAD = CTR_W'(READ_LATENCY - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        strb_q;
   logic [31:0]       rdata_q;
   logic [31:0]       off;
   logic              accept_err;
   logic              ctr_load;
   logic              ctr_dec;
   logic              ctr_done;
   logic [CTR_W-1:0]  ctr_val;

   assign off           = ext_address - BASE_ADDR;
   assign accept_err    = !addr_in_range(off, 32'(MEM_WORDS)) ||
                          (ext_instruction && (ext_write_strobe != 4'b0));
   assign ext_read_data = rdata_q;

   always_comb begin
      ctr_load = 1'b0;
      ctr_val  = '0;
      ctr_dec  = 1'b0;
      case (state)
         ST_IDLE: begin
            ctr_load = ext_valid;
            ctr_val  = WAIT_LOAD;
         end
         ST_ISSUE: begin
            ctr_load = 1'b1;
            ctr_val  = DATA_LOAD;
         end
         ST_WAIT, ST_DATA: ctr_dec = !ctr_done;
         default: ;
      endcase
   end

   ext_mem_cycle_ctr u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (ctr_dec),
      .done     (ctr_done)
   );

   // Outputs are registered alongside the state, so each pulse lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         rdata_q    <= '0;
         ext_ready  <= 1'b0;
         bus_err    <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= 4'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         ext_ready <= 1'b0;
         bus_err   <= 1'b0;
         sram_en   <= 1'b0;
         sram_we   <= 4'b0;
         case (state)
            ST_IDLE: begin
               if (ext_valid) begin
                  addr_q  <= off[ADDR_W+1:2];
                  wdata_q <= ext_write_data;
                  strb_q  <= ext_write_strobe;
                  if (accept_err) begin
                     state     <= ST_ERR;
                     ext_ready <= 1'b1;
                     bus_err   <= 1'b1;
                     rdata_q   <= '0;
                  end else if (WAIT_STATES > 0) begin
                     state <= ST_WAIT;
                  end else begin
                     state      <= ST_ISSUE;
                     sram_en    <= 1'b1;
                     sram_we    <= ext_write_strobe;
                     sram_addr  <= off[ADDR_W+1:2];
                     sram_wdata <= ext_write_data;
                  end
               end
            end
            ST_WAIT: begin
               if (ctr_done) begin
                  state      <= ST_ISSUE;
                  sram_en    <= 1'b1;
                  sram_we    <= strb_q;
                  sram_addr  <= addr_q;
                  sram_wdata <= wdata_q;
               end
            end
            ST_ISSUE: begin
               if (strb_q != 4'b0) begin
                  state     <= ST_RESP;
                  ext_ready <= 1'b1;
               end else begin
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (ctr_done) begin
                  rdata_q   <= sram_rdata;
                  state     <= ST_RESP;
                  ext_ready <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Bench for ext_mem_ctrl: three configurations, each with its own SRAM model,
// checked against a word-level reference memory and latency rules.
module tb_ext_mem_ctrl;

   localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
   localparam int          MEM_WORDS = 16384;
   localparam int          ADDR_W    = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
   localparam int          N_DUT     = 3;
   localparam int          WIN       = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic              valid_v [N_DUT];
   logic              instr_v;
   logic [31:0]       addr_v;
   logic [31:0]       wdata_v;
   logic [3:0]        strb_v;
   logic              rdy_w   [N_DUT];
   logic              err_w   [N_DUT];
   logic [31:0]       rd_w    [N_DUT];
   logic              en_w    [N_DUT];
   logic [3:0]        we_w    [N_DUT];
   logic [ADDR_W-1:0] sa_w    [N_DUT];
   logic [31:0]       wd_w    [N_DUT];
   logic [31:0]       srd_w   [N_DUT];

   // instance 0: no wait, latency 1; instance 1: 2 wait states; instance 2: latency 3
   function automatic int ws_of(input int g);
      return (g == 1) ? 2 : 0;
   endfunction

   function automatic int rl_of(input int g);
      return (g == 2) ? 3 : 1;
   endfunction

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int WS = (g == 1) ? 2 : 0;
      localparam int RL = (g == 2) ? 3 : 1;
      logic [31:0] mem  [MEM_WORDS];
      logic [31:0] pipe [4];

      ext_mem_ctrl #(
         .BASE_ADDR    (BASE_ADDR),
         .MEM_WORDS    (MEM_WORDS),
         .WAIT_STATES  (WS),
         .READ_LATENCY (RL)
      ) u_dut (
         .clk              (clk),
         .reset            (reset),
         .ext_valid        (valid_v[g]),
         .ext_instruction  (instr_v),
         .ext_address      (addr_v),
         .ext_write_data   (wdata_v),
         .ext_write_strobe (strb_v),
         .ext_ready        (rdy_w[g]),
         .ext_read_data    (rd_w[g]),
         .bus_err          (err_w[g]),
         .sram_en          (en_w[g]),
         .sram_we          (we_w[g]),
         .sram_addr        (sa_w[g]),
         .sram_wdata       (wd_w[g]),
         .sram_rdata       (srd_w[g])
      );

      always @(posedge clk) begin
         if (en_w[g]) begin
            for (int b = 0; b < 4; b++)
               if (we_w[g][b]) mem[sa_w[g]][8*b +: 8] <= wd_w[g][8*b +: 8];
            pipe[0] <= mem[sa_w[g]];
         end
         for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      end
      assign srd_w[g] = pipe[RL-1];
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd [N_DUT];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic check_zero(input int g, input string why);
      check($sformatf("%s_ready[%0d]", why, g), 32'(rdy_w[g]), 32'd0);
      check($sformatf("%s_bus_err[%0d]", why, g), 32'(err_w[g]), 32'd0);
      check($sformatf("%s_rdata[%0d]", why, g), rd_w[g], 32'd0);
      check($sformatf("%s_sram_en[%0d]", why, g), 32'(en_w[g]), 32'd0);
      check($sformatf("%s_sram_we[%0d]", why, g), 32'(we_w[g]), 32'd0);
      check($sformatf("%s_sram_addr[%0d]", why, g), 32'(sa_w[g]), 32'd0);
      check($sformatf("%s_sram_wdata[%0d]", why, g), wd_w[g], 32'd0);
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge while instance g is idle; returns at a falling edge of its next idle cycle.
   task automatic do_txn(input int g, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic hold,
                         output int ready_cyc);
      logic [31:0] off;
      logic        err;
      int          key, lat, c, en_seen, en_cyc, got;
      logic [31:0] exp_rd, old;

      off = addr - BASE_ADDR;
      err = (off >= MEM_BYTES) || (instr && (strb != 4'b0));
      key = g * MEM_WORDS + int'(off >> 2);
      if (err) begin
         lat    = 1;
         exp_rd = 32'd0;
      end else if (strb != 4'b0) begin
         lat    = 2 + ws_of(g);
         exp_rd = last_rd[g];
      end else begin
         lat    = 2 + ws_of(g) + rl_of(g);
         exp_rd = ref_mem[key];
      end
      exp_q.push_back(exp_rd);

      instr_v    = instr;
      addr_v     = addr;
      wdata_v    = wdata;
      strb_v     = strb;
      valid_v[g] = 1'b1;
      c = 0; en_seen = 0; en_cyc = 0; got = 0;
      while (got == 0 && c < 30) begin
         @(posedge clk);
         @(negedge clk);
         c++;
         if (c == 1 && !hold) valid_v[g] = 1'b0;
         if (en_w[g]) begin
            en_seen++;
            en_cyc = c;
            check($sformatf("sram_we[%0d]", g), 32'(we_w[g]), 32'(strb));
            check($sformatf("sram_addr[%0d]", g), 32'(sa_w[g]), 32'(ADDR_W'(off >> 2)));
            if (strb != 4'b0) check($sformatf("sram_wdata[%0d]", g), wd_w[g], wdata);
         end
         if (rdy_w[g]) got = 1;
      end
      check($sformatf("ready_seen[%0d]", g), 32'(got), 32'd1);
      check($sformatf("latency[%0d]", g), 32'(c), 32'(lat));
      check($sformatf("bus_err[%0d]", g), 32'(err_w[g]), 32'(err));
      check($sformatf("rdata[%0d]", g), rd_w[g], exp_q.pop_front());
      check($sformatf("sram_en_count[%0d]", g), 32'(en_seen), err ? 32'd0 : 32'd1);
      if (!err) check($sformatf("sram_en_cycle[%0d]", g), 32'(en_cyc), 32'(1 + ws_of(g)));
      ready_cyc = cyc;

      if (err) begin
         last_rd[g] = 32'd0;
      end else if (strb != 4'b0) begin
         old          = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
         ref_mem[key] = merge(old, wdata, strb);
      end else begin
         last_rd[g] = exp_rd;
      end
      if (!hold) valid_v[g] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("single_pulse[%0d]", g), 32'(rdy_w[g]), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          rc, r1, r2, r3, n_rdy, r;
      logic [31:0] a;
      logic [3:0]  s;
      logic        ins, hld;

      reset   = 1'b1;
      instr_v = 1'b0;
      addr_v  = '0;
      wdata_v = '0;
      strb_v  = '0;
      for (int g = 0; g < N_DUT; g++) begin
         valid_v[g] = 1'b0;
         last_rd[g] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < N_DUT; g++) check_zero(g, "reset");
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);

      for (int g = 0; g < N_DUT; g++)
         for (int w = 0; w < WIN; w++)
            do_txn(g, 1'b0, BASE_ADDR + 32'(4 * w), $urandom, 4'hF, 1'b0, rc);

      // fetch of a preloaded word, then errors and the last in-range word
      do_txn(0, 1'b0, BASE_ADDR, 32'hDEAD_BEEF, 4'hF, 1'b0, rc);
      do_txn(0, 1'b1, BASE_ADDR, 32'h0, 4'h0, 1'b0, rc);
      check("fetch_deadbeef", rd_w[0], 32'hDEAD_BEEF);
      do_txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0, rc);
      do_txn(0, 1'b0, BASE_ADDR + MEM_BYTES, 32'h0, 4'h0, 1'b0, rc);
      do_txn(0, 1'b1, BASE_ADDR, 32'hFFFF_FFFF, 4'hF, 1'b0, rc);
      do_txn(0, 1'b0, BASE_ADDR + MEM_BYTES - 4, 32'hA5A5_0F0F, 4'hF, 1'b0, rc);
      do_txn(0, 1'b0, BASE_ADDR + MEM_BYTES - 4, 32'h0, 4'h0, 1'b0, rc);

      // partial store with wait states
      do_txn(1, 1'b0, BASE_ADDR + 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, rc);
      do_txn(1, 1'b0, BASE_ADDR + 32'h10, 32'h1234_5678, 4'b0011, 1'b0, rc);
      do_txn(1, 1'b0, BASE_ADDR + 32'h10, 32'h0, 4'h0, 1'b0, rc);
      check("partial_store", rd_w[1], 32'hFFFF_5678);

      // back-to-back reads with ext_valid held high
      do_txn(2, 1'b0, BASE_ADDR + 32'h0, 32'h0, 4'h0, 1'b1, r1);
      do_txn(2, 1'b0, BASE_ADDR + 32'h4, 32'h0, 4'h0, 1'b1, r2);
      do_txn(2, 1'b0, BASE_ADDR + 32'h8, 32'h0, 4'h0, 1'b0, r3);
      check("b2b_spacing_1", 32'(r2 - r1), 32'(3 + ws_of(2) + rl_of(2)));
      check("b2b_spacing_2", 32'(r3 - r2), 32'(3 + ws_of(2) + rl_of(2)));

      // reset while instance 2 sits in its read-latency phase
      instr_v    = 1'b0;
      addr_v     = BASE_ADDR + 32'hC;
      strb_v     = 4'h0;
      valid_v[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_v[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero(2, "mid_reset");
      reset = 1'b0;
      for (int g = 0; g < N_DUT; g++) last_rd[g] = 32'd0;
      n_rdy = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (rdy_w[2]) n_rdy++;
      end
      check("no_ready_after_reset", 32'(n_rdy), 32'd0);
      do_txn(2, 1'b0, BASE_ADDR + 32'hC, 32'h0, 4'h0, 1'b0, rc);

      // randomized traffic
      for (int g = 0; g < N_DUT; g++) begin
         for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      a = BASE_ADDR - 32'(4 * $urandom_range(1, 64));
            else if (r == 1) a = BASE_ADDR + MEM_BYTES + 32'(4 * $urandom_range(0, 64));
            else             a = BASE_ADDR + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
            ins = ($urandom_range(0, 3) == 0);
            s   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            hld = ($urandom_range(0, 3) == 0);
            do_txn(g, ins, a, $urandom, s, hld, rc);
         end
         valid_v[g] = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
